pwm_generator: RTL

- Downstream consumer of the 8-bit triangle duty-ramp stage.
- Converts the ramp's duty word into a fixed-frequency PWM pair: pwm_out and complementary pwm_n, with dead-time inserted between them.
- Duty updates are double-buffered and take effect only at period boundaries, so a ramp value changing every clock never produces glitched pulses.
- The block drives the LED/motor pin stage.

---
 rtl/pwm_pkg.sv | 27 ++
 rtl/pwm_prescaler.sv | 45 ++++
 rtl/pwm_generator.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_pkg : shared state encoding, period helper and default parameters for  |
// |           the PWM generator and its prescaler.                             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pwm_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_PRESCALE = 4;
  localparam int unsigned DEF_DEADTIME = 2;

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_LO   = 3'd1,
    S_DT_H = 3'd2,
    S_HI   = 3'd3,
    S_DT_L = 3'd4
  } pwm_state_e;

  // Top count is one below all-ones so a full-scale duty word yields a constant high.
  function automatic int unsigned pwm_max_cnt(input int unsigned width);
    return (32'd1 << width) - 32'd2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_prescaler : divides clk into a one-cycle tick every PRESCALE cycles;   |
// |                 clr resets and holds the divider with no tick.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  // A one-bit divider is kept even for PRESCALE=1; it simply never leaves zero.
  localparam int unsigned      c_PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PW-1:0]  c_LAST = c_PW'(PRESCALE - 1);

  logic [c_PW-1:0] presc_q;
  logic [c_PW-1:0] presc_d;

  always_comb begin
    presc_d = presc_q;
    if (clr || (presc_q == c_LAST)) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = ~clr & (presc_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/pwm_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_generator : fixed-frequency complementary PWM with double-buffered     |
// |                 duty and dead-time insertion around every edge.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned DEADTIME = DEF_DEADTIME
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_load,
  output logic             pwm_out,
  output logic             pwm_n,
  output logic             period_end
);

  localparam logic [WIDTH-1:0] c_MAX_CNT = WIDTH'(pwm_max_cnt(WIDTH));
  localparam int unsigned      c_DTW     = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [c_DTW-1:0] c_DT_LOAD = (DEADTIME > 0) ? c_DTW'(DEADTIME - 1) : '0;

  logic             w_clr;
  logic             w_tick;
  logic             w_wrap;
  logic             w_raw;

  logic [WIDTH-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] active_q,  active_d;
  logic [c_DTW-1:0] dt_q,      dt_d;
  pwm_state_e       state_q,   state_d;
  logic             pwm_out_q, pwm_out_d;
  logic             pwm_n_q,   pwm_n_d;
  logic             period_end_q;

  // Timebase is frozen at zero whenever the output stage is idle or disabled.
  assign w_clr = ~en | (state_q == S_OFF);

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  assign w_wrap = w_tick & (cnt_q == c_MAX_CNT);
  assign w_raw  = (cnt_q < active_q);

  always_comb begin
    cnt_d     = cnt_q;
    active_d  = active_q;
    pending_d = duty_load ? duty_in : pending_q;
    if (w_clr) begin
      cnt_d = '0;
      if (en) begin
        active_d = pending_q;
      end
    end else if (w_wrap) begin
      cnt_d    = '0;
      active_d = pending_q;
    end else if (w_tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    dt_d    = dt_q;
    if (!en) begin
      state_d = S_OFF;
      dt_d    = '0;
    end else begin
      case (state_q)
        S_OFF: state_d = S_LO;
        S_LO: begin
          if (w_raw) begin
            if (DEADTIME == 0) begin
              state_d = S_HI;
            end else begin
              state_d = S_DT_H;
              dt_d    = c_DT_LOAD;
            end
          end
        end
        S_DT_H: begin
          if (!w_raw) begin
            state_d = S_LO;
          end else if (dt_q == '0) begin
            state_d = S_HI;
          end else begin
            dt_d = dt_q - 1'b1;
          end
        end
        S_HI: begin
          if (!w_raw) begin
            if (DEADTIME == 0) begin
              state_d = S_LO;
            end else begin
              state_d = S_DT_L;
              dt_d    = c_DT_LOAD;
            end
          end
        end
        S_DT_L: begin
          if (w_raw) begin
            state_d = S_HI;
          end else if (dt_q == '0) begin
            state_d = S_LO;
          end else begin
            dt_d = dt_q - 1'b1;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  // Outputs decode the next state so the pins are registered yet still move one clk after raw.
  always_comb begin
    pwm_out_d = 1'b0;
    pwm_n_d   = 1'b0;
    case (state_d)
      S_HI:    pwm_out_d = 1'b1;
      S_LO:    pwm_n_d   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      pending_q    <= '0;
      active_q     <= '0;
      dt_q         <= '0;
      state_q      <= S_OFF;
      pwm_out_q    <= 1'b0;
      pwm_n_q      <= 1'b0;
      period_end_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      dt_q         <= dt_d;
      state_q      <= state_d;
      pwm_out_q    <= pwm_out_d;
      pwm_n_q      <= pwm_n_d;
      period_end_q <= w_wrap;
    end
  end

  assign pwm_out    = pwm_out_q;
  assign pwm_n      = pwm_n_q;
  assign period_end = period_end_q;

endmodule
`default_nettype wire
